// File: rtl/sr_latch_checker_pkg.sv
// Shared definitions for the SR latch response checker: FSM state encoding
// and the set/reset input encodings seen on {s, r}.
package sr_latch_checker_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CHECK   = 2'd2,
        MONITOR = 2'd3
    } chk_state_t;

    localparam logic [1:0] SR_HOLD = 2'b00;
    localparam logic [1:0] SR_RST  = 2'b01;
    localparam logic [1:0] SR_SET  = 2'b10;
    localparam logic [1:0] SR_BAD  = 2'b11;

endpackage

// File: rtl/sr_latch_checker_ref_model.sv
// NOR-latch reference model: tracks what q should be and whether that value
// is defined, and turns the registered s/r into the expected q/qn pair.
// o_exp_strict=0 means the model state is unknown and only q!=qn is required.
module sr_ref_model
    import sr_latch_checker_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_change,
    input  logic [1:0] i_sr_new,
    input  logic [1:0] i_sr_reg,
    output logic       o_model_q,
    output logic       o_model_known,
    output logic       o_exp_q,
    output logic       o_exp_qn,
    output logic       o_exp_strict
);

    logic r_model_q;
    logic r_model_known;

    // Model state moves only when s/r changes, using the incoming s/r value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_model_q     <= 1'b0;
            r_model_known <= 1'b0;
        end else if (i_change) begin
            case (i_sr_new)
                SR_SET: begin
                    r_model_q     <= 1'b1;
                    r_model_known <= 1'b1;
                end
                SR_RST: begin
                    r_model_q     <= 1'b0;
                    r_model_known <= 1'b1;
                end
                SR_HOLD: begin
                    // Releasing both inputs together races the real latch.
                    if (i_sr_reg == SR_BAD) begin
                        r_model_known <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Expected response for the currently registered s/r.
    always_comb begin
        o_exp_q      = 1'b0;
        o_exp_qn     = 1'b0;
        o_exp_strict = 1'b1;
        if (i_sr_reg == SR_BAD) begin
            o_exp_q  = 1'b0;
            o_exp_qn = 1'b0;
        end else if (r_model_known) begin
            o_exp_q  = r_model_q;
            o_exp_qn = ~r_model_q;
        end else begin
            o_exp_strict = 1'b0;
        end
    end

    assign o_model_q     = r_model_q;
    assign o_model_known = r_model_known;

endmodule

// File: rtl/sr_latch_checker.sv
// SR latch response checker. Registers the latch stimulus and response,
// waits SETTLE_CYC cycles after any s/r change, then compares the latch
// against the reference model every cycle until the next change.
// Optional macro SR_CHK_ERR_LOG_EN: capture {s,r,q,qn} at the first mismatch
// since reset/clr on err_snap; otherwise err_snap is constant zero.
module sr_latch_checker
    import sr_latch_checker_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 s_in,
    input  logic                 r_in,
    input  logic                 q_in,
    input  logic                 qn_in,
    output logic                 check_valid,
    output logic                 mismatch,
    output logic                 forbidden,
    output logic                 model_q,
    output logic                 model_known,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [3:0]           err_snap
);

    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

    logic                 r_s_d;
    logic                 r_r_d;
    logic                 r_q_d;
    logic                 r_qn_d;
    chk_state_t           r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_forbidden;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    logic [1:0] w_sr_new;
    logic [1:0] w_sr_reg;
    logic       w_change;
    logic       w_exp_q;
    logic       w_exp_qn;
    logic       w_exp_strict;
    logic       w_bad;
    logic       w_check_valid;
    logic       w_mismatch;

    assign w_sr_new = {s_in, r_in};
    assign w_sr_reg = {r_s_d, r_r_d};
    assign w_change = (w_sr_new != w_sr_reg);

    // Single input register stage for stimulus and response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_d  <= 1'b0;
            r_r_d  <= 1'b0;
            r_q_d  <= 1'b0;
            r_qn_d <= 1'b0;
        end else begin
            r_s_d  <= s_in;
            r_r_d  <= r_in;
            r_q_d  <= q_in;
            r_qn_d <= qn_in;
        end
    end

    sr_ref_model u_ref_model (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_change      (w_change),
        .i_sr_new      (w_sr_new),
        .i_sr_reg      (w_sr_reg),
        .o_model_q     (model_q),
        .o_model_known (model_known),
        .o_exp_q       (w_exp_q),
        .o_exp_qn      (w_exp_qn),
        .o_exp_strict  (w_exp_strict)
    );

    // Settle/compare sequencing; any s/r change restarts the settle window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (!en) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= SETTLE;
                    r_cnt   <= CNT_LOAD;
                end
                SETTLE: begin
                    if (w_change) begin
                        r_cnt <= CNT_LOAD;
                    end else if (r_cnt == '0) begin
                        r_state <= CHECK;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                CHECK, MONITOR: begin
                    if (w_change) begin
                        r_state <= SETTLE;
                        r_cnt   <= CNT_LOAD;
                    end else begin
                        r_state <= MONITOR;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_check_valid = en && ((r_state == CHECK) || (r_state == MONITOR));
    assign w_bad = w_exp_strict ? ((r_q_d != w_exp_q) || (r_qn_d != w_exp_qn))
                                : (r_q_d == r_qn_d);
    assign w_mismatch = w_check_valid && w_bad;

    // Sticky forbidden flag and saturating error count; clr has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_forbidden <= 1'b0;
            r_err_cnt   <= '0;
        end else if (clr) begin
            r_forbidden <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            if (w_change && (w_sr_new == SR_BAD)) begin
                r_forbidden <= 1'b1;
            end
            if (w_mismatch && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

`ifdef SR_CHK_ERR_LOG_EN
    logic [3:0] r_err_snap;
    logic       r_snap_valid;

    // Freeze the first failing sample until the next clr or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_snap   <= 4'b0000;
            r_snap_valid <= 1'b0;
        end else if (clr) begin
            r_err_snap   <= 4'b0000;
            r_snap_valid <= 1'b0;
        end else if (w_mismatch && !r_snap_valid) begin
            r_err_snap   <= {r_s_d, r_r_d, r_q_d, r_qn_d};
            r_snap_valid <= 1'b1;
        end
    end

    assign err_snap = r_err_snap;
`else
    assign err_snap = 4'b0000;
`endif

    assign check_valid = w_check_valid;
    assign mismatch    = w_mismatch;
    assign forbidden   = r_forbidden;
    assign busy        = (r_state == SETTLE) || (r_state == CHECK);
    assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_sr_latch_checker.sv
// Bench for sr_latch_checker: directed phases with literal expectations,
// then randomized stimulus, all checked every cycle against a behavioural
// model built from settle-window arithmetic and latch truth rules.
module tb_sr_latch_checker;

    localparam int S = 2;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic clr = 1'b0;
    logic s_in = 1'b0;
    logic r_in = 1'b0;
    logic q_in = 1'b0;
    logic qn_in = 1'b0;

    logic         check_valid;
    logic         mismatch;
    logic         forbidden;
    logic         model_q;
    logic         model_known;
    logic         busy;
    logic [W-1:0] err_cnt;
    logic [3:0]   err_snap;

    int total = 0;
    int bad = 0;

    sr_latch_checker #(.SETTLE_CYC(S), .ERR_CNT_W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .clr         (clr),
        .s_in        (s_in),
        .r_in        (r_in),
        .q_in        (q_in),
        .qn_in       (qn_in),
        .check_valid (check_valid),
        .mismatch    (mismatch),
        .forbidden   (forbidden),
        .model_q     (model_q),
        .model_known (model_known),
        .busy        (busy),
        .err_cnt     (err_cnt),
        .err_snap    (err_snap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [1:0] m_sr;
    logic       m_qd, m_qnd, m_known, m_q, m_forb, m_snap_v;
    logic [7:0] m_err;
    logic [3:0] m_snap;
    int         m_run;    // consecutive enabled edges
    int         m_quiet;  // edges since the last s/r change

    // Checker is in a compare state once enabled past the entry edge plus a
    // full quiet settle window.
    function automatic logic exp_cmp_state();
        return (m_run >= S + 1) && (m_quiet >= S);
    endfunction

    function automatic logic exp_monitor_state();
        return (m_run >= S + 2) && (m_quiet >= S + 1);
    endfunction

    function automatic logic exp_cv();
        return exp_cmp_state() && en;
    endfunction

    function automatic logic exp_busy();
        return (m_run >= 1) && !exp_monitor_state();
    endfunction

    // Latch truth: forbidden input drives both outputs low, a defined state
    // gives complementary outputs, an undefined one must still be complementary.
    function automatic logic exp_bad();
        if (m_sr == 2'b11) return m_qd || m_qnd;
        if (m_known) return (m_qd != m_q) || (m_qnd != !m_q);
        return m_qd == m_qnd;
    endfunction

    function automatic logic exp_mm();
        return exp_cv() && exp_bad();
    endfunction

    function automatic logic [3:0] exp_snap();
`ifdef SR_CHK_ERR_LOG_EN
        return m_snap;
`else
        return 4'b0000;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic       mm;
        logic       chg;
        logic [1:0] nsr;
        if (!rst_n) begin
            m_sr = 2'b00; m_qd = 0; m_qnd = 0; m_known = 0; m_q = 0;
            m_forb = 0; m_err = 0; m_snap = 0; m_snap_v = 0;
            m_run = 0; m_quiet = 0;
        end else begin
            nsr = {s_in, r_in};
            chg = (nsr != m_sr);
            mm  = exp_mm();
            if (mm) begin
                if (m_err != 8'hFF) m_err = m_err + 8'd1;
                if (!m_snap_v) begin
                    m_snap   = {m_sr, m_qd, m_qnd};
                    m_snap_v = 1;
                end
            end
            if (chg && nsr == 2'b11) m_forb = 1;
            if (clr) begin
                m_err = 0; m_forb = 0; m_snap = 0; m_snap_v = 0;
            end
            if (chg) begin
                case (nsr)
                    2'b10: begin m_q = 1; m_known = 1; end
                    2'b01: begin m_q = 0; m_known = 1; end
                    2'b00: if (m_sr == 2'b11) m_known = 0;
                    default: ;
                endcase
            end
            m_run   = en ? ((m_run < 1000) ? m_run + 1 : m_run) : 0;
            m_quiet = chg ? 0 : ((m_quiet < 1000) ? m_quiet + 1 : m_quiet);
            m_sr  = nsr;
            m_qd  = q_in;
            m_qnd = qn_in;
        end
    end

    // Every-cycle compare against the model.
    always @(negedge clk) begin
        chk("check_valid", check_valid, exp_cv());
        chk("mismatch",    mismatch,    exp_mm());
        chk("forbidden",   forbidden,   m_forb);
        chk("model_q",     model_q,     m_q);
        chk("model_known", model_known, m_known);
        chk("busy",        busy,        exp_busy());
        chk("err_cnt",     err_cnt,     m_err);
        chk("err_snap",    err_snap,    exp_snap());
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        #1;
    endtask

    task automatic drive(input logic s, input logic r, input logic q, input logic qn);
        s_in = s; r_in = r; q_in = q; qn_in = qn;
    endtask

    logic       lat_q = 1'b0;
    logic [1:0] rsr;

    initial begin
        // Phase 1: reset
        step(3);
        chk("lit_rst_cv", check_valid, 1'b0);
        chk("lit_rst_busy", busy, 1'b0);
        chk("lit_rst_err", err_cnt, 8'd0);
        chk("lit_rst_known", model_known, 1'b0);
        rst_n = 1'b1;
        $display("phase 1: reset released");

        // Phase 2: enable with idle latch
        en = 1'b1;
        drive(0, 0, 0, 1);
        step(3);
        chk("lit_p2_cv", check_valid, 1'b1);
        chk("lit_p2_known", model_known, 1'b0);
        chk("lit_p2_mm", mismatch, 1'b0);
        chk("lit_p2_err", err_cnt, 8'd0);
        $display("phase 2: first compare after settle");

        // Phase 3: set then reset with a good latch
        drive(1, 0, 1, 0);
        step(1);
        chk("lit_p3_busy", busy, 1'b1);
        chk("lit_p3_cv0", check_valid, 1'b0);
        chk("lit_p3_mq1", model_q, 1'b1);
        step(2);
        chk("lit_p3_cvchk", check_valid, 1'b1);
        chk("lit_p3_busychk", busy, 1'b1);
        step(1);
        chk("lit_p3_busymon", busy, 1'b0);
        chk("lit_p3_mm", mismatch, 1'b0);
        drive(0, 1, 0, 1);
        step(4);
        chk("lit_p3_mq0", model_q, 1'b0);
        chk("lit_p3_mm2", mismatch, 1'b0);
        $display("phase 3: set/reset tracked");

        // Phase 4: stuck latch saturates the counter; clr wins over mismatch
        drive(1, 0, 0, 1);
        step(300);
        chk("lit_p4_err_sat", err_cnt, 8'hFF);
        chk("lit_p4_mm", mismatch, 1'b1);
`ifdef SR_CHK_ERR_LOG_EN
        chk("lit_p4_snap", err_snap, 4'b1001);
`endif
        drive(1, 0, 1, 0);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("lit_p4_clr_err", err_cnt, 8'd0);
        chk("lit_p4_clr_snap", err_snap, 4'b0000);
        chk("lit_p4_clr_mm", mismatch, 1'b0);
        $display("phase 4: saturation and clear");

        // Phase 5: forbidden input, then release into unknown state
        drive(1, 1, 0, 0);
        step(4);
        chk("lit_p5_forb", forbidden, 1'b1);
        chk("lit_p5_mm", mismatch, 1'b0);
        drive(0, 0, 1, 0);
        step(4);
        chk("lit_p5_known", model_known, 1'b0);
        chk("lit_p5_mm2", mismatch, 1'b0);
        drive(0, 0, 1, 1);
        step(1);
        chk("lit_p5_mm3", mismatch, 1'b1);
        drive(0, 0, 1, 0);
        $display("phase 5: forbidden and unknown state");

        // Phase 6: continuous toggling keeps the checker settling
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) drive(1, 0, 1, 0);
            else            drive(0, 1, 0, 1);
            step(1);
            chk("lit_p6_cv_toggle", check_valid, 1'b0);
        end
        step(1);
        chk("lit_p6_cv_wait", check_valid, 1'b0);
        step(1);
        chk("lit_p6_cv_resume", check_valid, 1'b1);
        $display("phase 6: toggle holds off compare");

        // Phase 7: five errors, then asynchronous reset mid-monitor
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        drive(1, 0, 0, 1);
        step(5);
        drive(1, 0, 1, 0);
        step(1);
        chk("lit_p7_err5", err_cnt, 8'd5);
        rst_n = 1'b0;
        #1;
        chk("lit_p7_rst_cv", check_valid, 1'b0);
        chk("lit_p7_rst_mm", mismatch, 1'b0);
        chk("lit_p7_rst_forb", forbidden, 1'b0);
        chk("lit_p7_rst_mq", model_q, 1'b0);
        chk("lit_p7_rst_known", model_known, 1'b0);
        chk("lit_p7_rst_busy", busy, 1'b0);
        chk("lit_p7_rst_err", err_cnt, 8'd0);
        chk("lit_p7_rst_snap", err_snap, 4'b0000);
        step(2);
        rst_n = 1'b1;
        $display("phase 7: asynchronous reset");

        // Phase 8: randomized traffic with an occasionally faulty latch
        drive(0, 0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            en  = ($urandom_range(0, 31) != 0);
            clr = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 3) == 0) begin
                rsr = 2'($urandom_range(0, 3));
                case (rsr)
                    2'b10: lat_q = 1'b1;
                    2'b01: lat_q = 1'b0;
                    2'b00: if ({s_in, r_in} == 2'b11) lat_q = 1'($urandom_range(0, 1));
                    default: ;
                endcase
                s_in = rsr[1];
                r_in = rsr[0];
            end
            if ({s_in, r_in} == 2'b11) begin
                q_in = 1'b0; qn_in = 1'b0;
            end else begin
                q_in = lat_q; qn_in = ~lat_q;
            end
            if ($urandom_range(0, 19) == 0) begin
                q_in  = 1'($urandom_range(0, 1));
                qn_in = 1'($urandom_range(0, 1));
            end
            step(1);
        end
        clr = 1'b0;
        step(2);
        $display("phase 8: random traffic done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
